// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset value, instruction field positions and the
// internal encodings used by the YASAC fetch stage.
package fetch_unit_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_RESET_PC = 0;

    // Opcode field of an instruction word
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;

    // Next-PC source selected by the fetch control
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INCR = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_t;

    // Occupancy of the instruction register
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with its next-value multiplexer.
// Increments wrap modulo 2^ADDR_W.
module fetch_pc
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_t           sel,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_next;

    // Choose the next PC: redirect target, sequential increment or hold
    always_comb begin
        pc_next = pc;
        case (sel)
            PC_LOAD: pc_next = target;
            PC_INCR: pc_next = pc + 1'b1;
            default: pc_next = pc;
        endcase
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= ADDR_W'(RESET_PC);
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// YASAC instruction fetch stage: drives code_mem from the PC, latches
// the returned word into the instruction register and offers it
// downstream with valid/ready. Handles redirects and CPSE skips.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_EMPTY | instruction register holds nothing live (valid=0)
// ST_FULL  | instruction register holds a live instruction
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  code_addr,
    input  logic [INSTR_W-1:0] code_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  target,
    input  logic               skip,
    output logic [15:0]        fetch_count
);

    fetch_state_t      state;
    pc_sel_t           pc_sel;
    logic [ADDR_W-1:0] pc;
    logic              accept;
    logic              advance;

    assign instr_valid = (state == ST_FULL);
    assign accept      = instr_valid & instr_ready;
    assign advance     = ~instr_valid | instr_ready;
    assign code_addr   = pc;

    // PC moves on any advance (including a skip, which steps over the
    // word at PC); a redirect overrides everything
    always_comb begin
        pc_sel = PC_HOLD;
        if (redirect) begin
            pc_sel = PC_LOAD;
        end else if (advance) begin
            pc_sel = PC_INCR;
        end
    end

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .sel    (pc_sel),
        .target (target),
        .pc     (pc)
    );

    // Instruction register, occupancy state and delivered-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            // An accept counts even when a redirect flushes the pipe
            if (accept) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (redirect) begin
                state <= ST_EMPTY;
            end else if (advance && skip && accept) begin
                // The word currently at PC is the one being skipped
                state <= ST_EMPTY;
            end else if (advance) begin
                instr    <= code_data;
                instr_pc <= pc;
                state    <= ST_FULL;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the main flow plus
// hand sequences for asynchronous reset and long-run wrap-around.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  code_addr;
    logic [15:0] code_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  target;
    logic        skip;
    logic [15:0] fetch_count;

    int tests;
    int fails;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_addr   (code_addr),
        .code_data   (code_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .target      (target),
        .skip        (skip),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Code memory image: CODE[a] = 0x1001 + a
    always_comb code_data = 16'h1001 + {8'h00, code_addr};

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [7:0]  tgt;
        logic        skp;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [7:0]  e_ipc;
        logic [7:0]  e_addr;
        logic [15:0] e_count;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [15:0] ei,
                             input logic [7:0] eipc, input logic [7:0] ea, input logic [15:0] ec);
        check({tag, " valid"}, 32'(instr_valid), 32'(ev));
        check({tag, " instr"}, 32'(instr), 32'(ei));
        check({tag, " instr_pc"}, 32'(instr_pc), 32'(eipc));
        check({tag, " code_addr"}, 32'(code_addr), 32'(ea));
        check({tag, " fetch_count"}, 32'(fetch_count), 32'(ec));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        //            rdy   redir tgt    skp   valid instr     ipc    addr   count
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1001, 8'h00, 8'h01, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1002, 8'h01, 8'h02, 16'd1};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1003, 8'h02, 8'h03, 16'd2};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1004, 8'h03, 8'h04, 16'd3};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h1004, 8'h03, 8'h05, 16'd4};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1006, 8'h05, 8'h06, 16'd4};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1006, 8'h05, 8'h06, 16'd4};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1006, 8'h05, 8'h06, 16'd4};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1006, 8'h05, 8'h06, 16'd4};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1006, 8'h05, 8'h06, 16'd4};
        vecs[10] = '{1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 16'h1006, 8'h05, 8'h40, 16'd5};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1041, 8'h40, 8'h41, 16'd5};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h1041, 8'h40, 8'h41, 16'd5};
        vecs[13] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 16'h1041, 8'h40, 8'hFF, 16'd5};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h1100, 8'hFF, 8'h00, 16'd5};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1001, 8'h00, 8'h01, 16'd6};
        vecs[16] = '{1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 16'h1001, 8'h00, 8'h10, 16'd7};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1011, 8'h10, 8'h11, 16'd7};

        rst_n       = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        target      = 8'h00;
        skip        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 16'h0000, 8'h00, 8'h00, 16'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            instr_ready = vecs[i].rdy;
            redirect    = vecs[i].redir;
            target      = vecs[i].tgt;
            skip        = vecs[i].skp;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                      vecs[i].e_ipc, vecs[i].e_addr, vecs[i].e_count);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a stall with a live instruction
        instr_ready = 1'b0;
        redirect    = 1'b0;
        skip        = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 16'h0000, 8'h00, 8'h00, 16'd0);

        // Restart: first instruction one edge after release
        @(negedge clk);
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        check_all("restart", 1'b1, 16'h1001, 8'h00, 8'h01, 16'd0);

        // Streaming run to the counter wrap point
        repeat (65535) @(posedge clk);
        #1;
        check_all("cnt_max", 1'b1, 16'h1100, 8'hFF, 8'h00, 16'hFFFF);
        @(posedge clk);
        #1;
        check_all("cnt_wrap", 1'b1, 16'h1001, 8'h00, 8'h01, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
